// File: rtl/arb_pkg.sv
// Shared sizing constants and FSM state encoding for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/dec2to4.sv
// 2-bit index to 4-bit one-hot decoder with enable; all zeros when disabled.
module dec2to4 (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot = 4'b0001 << idx;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter: IDLE -> BUSY -> GAP FSM with a rotating priority pointer.
// Optional forced release after MAXHOLD busy cycles when RR_ARB4_TIMEOUT_EN is defined.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int MAXHOLD = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] R,
    input  logic               Done,
    output logic [NUM_REQ-1:0] G,
    output logic [IDX_W-1:0]   W,
    output logic               Busy,
    output logic               Tmo
);

    if (MAXHOLD < 2 || MAXHOLD > 255) begin : g_bad_maxhold
        $error("rr_arb4: MAXHOLD must be in 2..255");
    end

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   w_q;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   probe;
    logic               found;
    logic               any_req;
    logic               grant_now;
    logic               owner_release;
    logic               force_tmo;

    assign any_req       = |R;
    assign grant_now     = (state_q == IDLE) && any_req;
    assign owner_release = Done || !R[w_q];

    // First set request found scanning upward from the pointer, wrapping modulo 4.
    always_comb begin
        winner = ptr_q;
        probe  = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            probe = ptr_q + IDX_W'(i);
            if (!found && R[probe]) begin
                winner = probe;
                found  = 1'b1;
            end
        end
    end

`ifdef RR_ARB4_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       tmo_q;

    // Hold counter restarts at each grant, so it reads k on the (k+1)th busy cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hold_q <= 8'd0;
        end else if (grant_now) begin
            hold_q <= 8'd0;
        end else if (state_q == BUSY) begin
            hold_q <= hold_q + 8'd1;
        end
    end

    assign force_tmo = (state_q == BUSY) && !owner_release &&
                       (hold_q == 8'(MAXHOLD - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= force_tmo;
        end
    end

    assign Tmo = tmo_q;
`else
    assign force_tmo = 1'b0;
    assign Tmo       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (owner_release || force_tmo) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                w_q   <= winner;
                ptr_q <= winner + IDX_W'(1);
            end
        end
    end

    assign W    = w_q;
    assign Busy = (state_q == BUSY);

    dec2to4 u_dec (
        .idx    (w_q),
        .en     (Busy),
        .onehot (G)
    );

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter MAXHOLD, default 16, SHALL set the maximum cycles a grant is held before forced release (range 2..255; used only with timeout compiled in).
REQ-002 Clock  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  SHALL be asynchronous and active-high.
REQ-004 R  input  4  SHALL be the request vector; bit k is the request from requester k.
REQ-005 Done  input  1  SHALL be the release strobe from the current owner.
REQ-006 G  output  4  SHALL be the one-hot grant vector, registered.
REQ-007 W  output  2  SHALL be the binary index of the current owner, registered.
REQ-008 Busy  output  1  SHALL be high while any grant is active.
REQ-009 Tmo  output  1  SHALL be a one-cycle pulse marking a forced release.

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY and GAP.
REQ-011 IDLE with R==0 SHALL remain in IDLE.
REQ-012 IDLE with R!=0 SHALL select a winner, register it into W and G, and move to BUSY in the same edge; request-to-grant latency SHALL be 1 cycle.
REQ-013 Winner selection SHALL be round-robin: search SHALL start at index Ptr and proceed Ptr, Ptr+1, ... modulo 4; the first set bit SHALL win.
REQ-014 On each grant, Ptr SHALL be loaded with winner+1 modulo 4, wrapping 3->0.
REQ-015 In BUSY, G SHALL equal the decode of W with enable 1, Busy SHALL be 1, and W SHALL be stable.
REQ-016 In BUSY, Done=1 or R[W]=0 SHALL end the grant at the next edge and move to GAP; a simultaneous Done and drop SHALL count as one release.
REQ-017 Requests from non-owners in BUSY SHALL be ignored, neither stored nor preempting.
REQ-018 GAP SHALL last exactly one cycle with G=0 and Busy=0, then return to IDLE; the minimum grant-to-grant spacing is therefore 2 idle cycles after release.
REQ-019 In IDLE and GAP, G SHALL be 0 and Busy SHALL be 0; W SHALL hold the last owner.
REQ-020 Done asserted outside BUSY SHALL be ignored.
REQ-021 G SHALL never have more than one bit set in any cycle.

Reset
REQ-022 Reset SHALL force state IDLE, G=0, W=0, Busy=0, Tmo=0, Ptr=0 and hold count=0 immediately, independent of Clock.
REQ-023 Reset asserted mid-grant SHALL drop G in the same cycle; after deassertion, arbitration SHALL restart from Ptr=0.

Configuration
REQ-024 Macro RR_ARB4_TIMEOUT_EN, when defined, SHALL include an 8-bit hold counter that is cleared on grant and increments each BUSY cycle.
REQ-025 With the timeout included, reaching count MAXHOLD-1 in BUSY without a release SHALL force the transition to GAP and pulse Tmo high for that one transition cycle. Done on the same cycle SHALL take precedence, with Tmo=0.
REQ-026 Without the macro, no counter SHALL exist, Tmo SHALL be tied to 0, and grants SHALL be held indefinitely.

Structure
REQ-027 Shared package arb_pkg SHALL hold NUM_REQ=4, IDX_W=2, and the state encoding (IDLE=2'b00, BUSY=2'b01, GAP=2'b10).
REQ-028 G SHALL be produced by one sub-module instance, dec2to4 (2-bit index plus enable to 4-bit one-hot), fed by W and the BUSY state flag.
REQ-029 All other logic (priority search, FSM, counter) SHALL be in rr_arb4.

Verification
REQ-030 Scenario: Reset, then R=4'b0000 for 10 cycles -> G=0, Busy=0, W=0 throughout.
REQ-031 Scenario: R=4'b1111 held, Done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0; G=0001,0010,0100,1000,0001, each separated by one GAP cycle.
REQ-032 Scenario: Ptr=2 after a grant to 1, then R=4'b0011 -> grant to 0 (wrap), W=0, Ptr becomes 1.
REQ-033 Scenario: Owner 1 granted, R changes to 4'b1101 (owner drops) -> next edge G=0 (GAP), then grant to 2.
REQ-034 Scenario: With RR_ARB4_TIMEOUT_EN and MAXHOLD=4, owner holds R and never asserts Done -> G drops after 4 BUSY cycles, Tmo=1 for exactly 1 cycle. Without the macro, G is held for 100 cycles and Tmo stays 0.
REQ-035 Scenario: Reset asserted during BUSY with G=0100 -> G=0 before the next Clock edge; after release, R=4'b1111 grants 0 first.
